// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types for the up/down modulo counter subsystem.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    // Per-cycle counting mode; encodings are shared with stimulus code.
    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides advance requests by PRESCALE and emits a one-cycle
//                tick on the last advance of each period. clr restarts the
//                period and takes precedence over adv.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_passthrough
            // Every advance is a step; no divider state is needed.
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst, clr};
            assign tick        = adv;
        end else begin : g_divider
            localparam int               PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
            localparam logic [PW-1:0]    C_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_q;
            logic [PW-1:0] pre_d;

            assign tick = adv && (pre_q == C_LAST);

            // Next divider value: clear wins, otherwise advance and roll over.
            always_comb begin
                pre_d = pre_q;
                if (clr) begin
                    pre_d = '0;
                end else if (adv) begin
                    pre_d = (pre_q == C_LAST) ? '0 : pre_q + PW'(1);
                end
            end

            // Divider state register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end
        end
    endgenerate

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : WIDTH-bit modulo counter (0..MAX) with up/down/bounce/hold
//                modes, clamped synchronous load, enable prescaler, and a
//                registered wrap pulse for cascading.
//  Revision    : 1.0  initial release
// ============================================================================
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = (1 << WIDTH) - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             wrap,
    output logic             tick
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q,   dir_d;
    logic             wrap_q,  wrap_d;
    logic             w_adv;

    // HOLD freezes the prescaler as well as the count.
    assign w_adv = en && (mode != MODE_HOLD);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .adv  (w_adv),
        .tick (tick)
    );

    // Next-state: load beats step; a tick arriving with load is dropped.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > C_MAX) ? C_MAX : load_val;
        end else if (tick) begin
            case (mode)
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (count_q == C_MAX) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + C_ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == '0) begin
                        count_d = C_MAX;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - C_ONE;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (count_q == C_MAX) begin
                            count_d = C_MAX - C_ONE;
                            dir_d   = 1'b0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + C_ONE;
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = C_ONE;
                            dir_d   = 1'b1;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - C_ONE;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Count, direction and wrap registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign wrap  = wrap_q;

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_mod_counter
//  Description : Directed bench for updown_mod_counter. Four instances share
//                stimulus and differ in MAX / PRESCALE:
//                  A: MAX=9 P=1   B: MAX=3 P=1   C: MAX=1 P=1   D: MAX=9 P=3
//  Revision    : 1.0  initial release
// ============================================================================
module tb_updown_mod_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    mode_e      mode;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] a_count, b_count, c_count, d_count;
    logic       a_dir, b_dir, c_dir, d_dir;
    logic       a_wrap, b_wrap, c_wrap, d_wrap;
    logic       a_tick, b_tick, c_tick, d_tick;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(a_count), .dir(a_dir), .wrap(a_wrap), .tick(a_tick));
    updown_mod_counter #(.WIDTH(4), .MAX(3), .PRESCALE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(b_count), .dir(b_dir), .wrap(b_wrap), .tick(b_tick));
    updown_mod_counter #(.WIDTH(4), .MAX(1), .PRESCALE(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(c_count), .dir(c_dir), .wrap(c_wrap), .tick(c_tick));
    updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3)) u_d (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(d_count), .dir(d_dir), .wrap(d_wrap), .tick(d_tick));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected sequences, hand computed.
    int up_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int bb_cnt [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
    int bb_wrp [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    int bb_dir [8]  = '{1, 1, 1, 0, 0, 0, 1, 1};
    int bc_cnt [8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
    int bc_wrp [8]  = '{0, 1, 1, 1, 1, 1, 1, 1};
    int ps_tick[6]  = '{0, 0, 1, 0, 0, 1};
    int ps_cnt [6]  = '{0, 0, 1, 1, 1, 2};
    int st_en  [5]  = '{1, 0, 0, 1, 1};
    int st_tick[5]  = '{0, 0, 0, 0, 1};
    int st_cnt [5]  = '{2, 2, 2, 2, 3};

    initial begin
        // Reset state
        rst = 1'b1; en = 1'b0; mode = MODE_UP; load = 1'b0; load_val = 4'd0;
        cyc(); cyc();
        chk("rst_count", 32'(a_count), 0);
        chk("rst_dir",   32'(a_dir),   1);
        chk("rst_wrap",  32'(a_wrap),  0);
        chk("rst_tick",  32'(a_tick),  0);

        // UP, MAX=9
        rst = 1'b0; en = 1'b1; mode = MODE_UP;
        #1 chk("up_tick", 32'(a_tick), 1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("up_count", 32'(a_count), 32'(up_cnt[i]));
            chk("up_wrap",  32'(a_wrap),  (i == 9) ? 1 : 0);
            chk("up_dir",   32'(a_dir),   1);
        end

        // DOWN from reset, then HOLD
        rst = 1'b1; cyc();
        rst = 1'b0; mode = MODE_DOWN;
        cyc();
        chk("dn_first_count", 32'(a_count), 9);
        chk("dn_first_wrap",  32'(a_wrap),  1);
        chk("dn_first_dir",   32'(a_dir),   0);
        cyc(); chk("dn_count8", 32'(a_count), 8); chk("dn_wrap8", 32'(a_wrap), 0);
        cyc(); chk("dn_count7", 32'(a_count), 7);
        mode = MODE_HOLD;
        #1 chk("hold_tick", 32'(a_tick), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_count", 32'(a_count), 7);
            chk("hold_wrap",  32'(a_wrap),  0);
            chk("hold_dir",   32'(a_dir),   0);
            chk("hold_tick",  32'(a_tick),  0);
        end

        // BOUNCE: MAX=3 on B, MAX=1 on C
        rst = 1'b1; cyc();
        rst = 1'b0; mode = MODE_BOUNCE;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("bnc3_count", 32'(b_count), 32'(bb_cnt[i]));
            chk("bnc3_wrap",  32'(b_wrap),  32'(bb_wrp[i]));
            chk("bnc3_dir",   32'(b_dir),   32'(bb_dir[i]));
            chk("bnc1_count", 32'(c_count), 32'(bc_cnt[i]));
            chk("bnc1_wrap",  32'(c_wrap),  32'(bc_wrp[i]));
        end

        // PRESCALE=3 on D, then en dropped for two cycles
        rst = 1'b1; cyc();
        rst = 1'b0; mode = MODE_UP; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 chk("ps_tick", 32'(d_tick), 32'(ps_tick[i]));
            cyc();
            chk("ps_count", 32'(d_count), 32'(ps_cnt[i]));
        end
        for (int i = 0; i < 5; i++) begin
            en = st_en[i][0];
            #1 chk("ps_stretch_tick", 32'(d_tick), 32'(st_tick[i]));
            cyc();
            chk("ps_stretch_count", 32'(d_count), 32'(st_cnt[i]));
        end

        // Clamped load coincident with tick; prescaler clear on D
        rst = 1'b1; cyc();
        rst = 1'b0; mode = MODE_UP; en = 1'b1;
        cyc();
        chk("ld_pre_count", 32'(a_count), 1);
        load = 1'b1; load_val = 4'd15;
        #1 chk("ld_tick_coincident", 32'(a_tick), 1);
        cyc();
        chk("ld_count_clamp9", 32'(a_count), 9);
        chk("ld_wrap",         32'(a_wrap),  0);
        chk("ld_dir",          32'(a_dir),   1);
        chk("ld_count_clamp3", 32'(b_count), 3);
        chk("ld_d_count",      32'(d_count), 9);
        load = 1'b0;
        #1 chk("ld_d_tick0", 32'(d_tick), 0);
        cyc();
        chk("ld_after_count", 32'(a_count), 0);
        chk("ld_after_wrap",  32'(a_wrap),  1);
        #1 chk("ld_d_tick1", 32'(d_tick), 0);
        cyc();
        #1 chk("ld_d_tick2", 32'(d_tick), 1);
        cyc();
        chk("ld_d_wrap_count", 32'(d_count), 0);
        chk("ld_d_wrap",       32'(d_wrap),  1);
        // Unclamped load
        load = 1'b1; load_val = 4'd5;
        cyc();
        chk("ld_count5", 32'(a_count), 5);
        load = 1'b0;

        // Reset together with load, then reset mid-count
        rst = 1'b1; load = 1'b1; load_val = 4'd5;
        cyc();
        chk("rstld_count", 32'(a_count), 0);
        chk("rstld_dir",   32'(a_dir),   1);
        chk("rstld_wrap",  32'(a_wrap),  0);
        rst = 1'b0; load = 1'b0; mode = MODE_DOWN;
        cyc();
        chk("rm_count9", 32'(a_count), 9);
        chk("rm_dir0",   32'(a_dir),   0);
        cyc();
        chk("rm_count8", 32'(a_count), 8);
        rst = 1'b1;
        cyc();
        chk("rm_rst_count", 32'(a_count), 0);
        chk("rm_rst_dir",   32'(a_dir),   1);
        chk("rm_rst_wrap",  32'(a_wrap),  0);
        rst = 1'b0; mode = MODE_UP;
        cyc();
        chk("rm_resume", 32'(a_count), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule : tb_updown_mod_counter
`default_nettype wire
